// File: rtl/acorn128_tag_verify.sv
// Purpose: ACORN-128 decrypt-side tag check. Runs 768 finalization steps on the
//          latched state, recomputes the tag and compares it to the received tag.
// Latency: start->done 769 clocks, one verification per 770 clocks; start is ignored unless idle.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             single-cycle request, sampled only in IDLE
//   state_in[292:0]   cipher state after the last ciphertext step (sampled with start)
//   tag_in[127:0]     received tag (sampled with start)
//   busy              high while finalization steps run
//   done              one-cycle pulse when tag_ok/tag_out become valid
//   tag_ok            recomputed tag == latched received tag (held until next start/reset)
//   tag_out[127:0]    recomputed tag (held alongside tag_ok)
module acorn128_tag_verify (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [292:0] state_in,
  input  logic [127:0] tag_in,
  output logic         busy,
  output logic         done,
  output logic         tag_ok,
  output logic [127:0] tag_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } fsm_t;

  localparam logic [9:0] LAST_STEP    = 10'd767;
  localparam logic [9:0] FIRST_TAG_KS = 10'd640;

  fsm_t         fsm;
  logic [292:0] s;
  logic [127:0] tag_exp;
  logic [127:0] tag_acc;
  logic [9:0]   cnt;

  // Combinational step outputs
  logic [292:0] s_fb;
  logic [292:0] s_next;
  logic         ks;
  logic         f;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

  // One ACORN step with ca = cb = 1 and m = 0.
  // Each LFSR feedback only reads taps that no later feedback in the chain has
  // modified yet, so all six XORs can be taken from the pre-step state. The
  // keystream and f then read the updated taps.
  always_comb begin
    s_fb      = s;
    s_fb[289] = s[289] ^ s[235] ^ s[230];
    s_fb[230] = s[230] ^ s[196] ^ s[193];
    s_fb[193] = s[193] ^ s[160] ^ s[154];
    s_fb[154] = s[154] ^ s[111] ^ s[107];
    s_fb[107] = s[107] ^ s[66]  ^ s[61];
    s_fb[61]  = s[61]  ^ s[23]  ^ s[0];

    ks = s_fb[12] ^ s_fb[154]
       ^ maj(s_fb[235], s_fb[61], s_fb[193])
       ^ ch(s_fb[230], s_fb[111], s_fb[66]);

    f = s_fb[0] ^ ~s_fb[107]
      ^ maj(s_fb[244], s_fb[23], s_fb[160])
      ^ s_fb[196] ^ ks;

    s_next = {f, s_fb[292:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm     <= IDLE;
      s       <= '0;
      tag_exp <= '0;
      tag_acc <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      tag_ok  <= 1'b0;
      tag_out <= '0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            s       <= state_in;
            tag_exp <= tag_in;
            tag_acc <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            fsm     <= RUN;
          end
        end

        RUN: begin
          s   <= s_next;
          cnt <= cnt + 10'd1;
          // Shift in from the MSB: after 128 captures the step-640 bit sits at
          // bit 0 and the step-767 bit at bit 127.
          if (cnt >= FIRST_TAG_KS) begin
            tag_acc <= {ks, tag_acc[127:1]};
          end
          if (cnt == LAST_STEP) begin
            busy <= 1'b0;
            fsm  <= FIN;
          end
        end

        FIN: begin
          done    <= 1'b1;
          tag_ok  <= (tag_acc == tag_exp);
          tag_out <= tag_acc;
          fsm     <= IDLE;
        end

        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acorn128_tag_verify.sv
module tb_acorn128_tag_verify;

  logic         clk;
  logic         rst;
  logic         start;
  logic [292:0] state_in;
  logic [127:0] tag_in;
  logic         busy;
  logic         done;
  logic         tag_ok;
  logic [127:0] tag_out;

  int n_cmp = 0;
  int n_err = 0;

  acorn128_tag_verify dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .state_in (state_in),
    .tag_in   (tag_in),
    .busy     (busy),
    .done     (done),
    .tag_ok   (tag_ok),
    .tag_out  (tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: runs the finalization on an array of bits, step by step in the
  // order the algorithm states, and writes the tag by index.
  function automatic logic [127:0] model_tag(input logic [292:0] init);
    bit st [0:292];
    bit k;
    bit fb;
    logic [127:0] t;
    t = '0;
    for (int i = 0; i < 293; i++) st[i] = init[i];
    for (int step = 0; step < 768; step++) begin
      st[289] = st[289] ^ st[235] ^ st[230];
      st[230] = st[230] ^ st[196] ^ st[193];
      st[193] = st[193] ^ st[160] ^ st[154];
      st[154] = st[154] ^ st[111] ^ st[107];
      st[107] = st[107] ^ st[66]  ^ st[61];
      st[61]  = st[61]  ^ st[23]  ^ st[0];
      k = st[12] ^ st[154]
        ^ ((st[235] & st[61]) ^ (st[235] & st[193]) ^ (st[61] & st[193]))
        ^ ((st[230] & st[111]) ^ (!st[230] & st[66]));
      fb = st[0] ^ !st[107]
         ^ ((st[244] & st[23]) ^ (st[244] & st[160]) ^ (st[23] & st[160]))
         ^ st[196] ^ k;
      for (int j = 0; j < 292; j++) st[j] = st[j + 1];
      st[292] = fb;
      if (step >= 640) t[step - 640] = k;
    end
    return t;
  endfunction

  function automatic logic [292:0] rand_state();
    logic [292:0] v;
    v = '0;
    repeat (10) v = {v[260:0], 32'($urandom)};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Issues one start, scrambles the inputs afterwards, and waits (bounded) for done.
  task automatic do_run(input logic [292:0] st, input logic [127:0] tg, output int lat);
    state_in = st;
    tag_in   = tg;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    state_in = ~st;
    tag_in   = ~tg;
    chk("busy_after_start", 128'(busy), 128'd1);
    lat = 0;
    while (!done && lat < 2000) begin
      tick();
      lat++;
    end
  endtask

  // Full run plus checks of latency, result, and single-cycle done.
  task automatic run_check(input string name, input logic [292:0] st, input logic [127:0] tg,
                           input logic exp_ok, input logic [127:0] exp_tag);
    int lat;
    do_run(st, tg, lat);
    chk({name, "_latency"}, 128'(lat), 128'd769);
    chk({name, "_busy_at_done"}, 128'(busy), 128'd0);
    chk({name, "_tag_ok"}, 128'(tag_ok), 128'(exp_ok));
    chk({name, "_tag_out"}, tag_out, exp_tag);
    tick();
    chk({name, "_done_one_cycle"}, 128'(done), 128'd0);
  endtask

  initial begin
    logic [127:0] gold;
    logic [127:0] t;
    logic [127:0] ta;
    logic [127:0] tb2;
    logic [292:0] st;
    logic [292:0] sb;
    int           lat;
    int           k;
    int           pulses;
    int           first_pulse;
    int           second_pulse;
    int           held_bad;

    rst      = 1'b1;
    start    = 1'b0;
    state_in = '0;
    tag_in   = '0;
    repeat (3) tick();
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_tag_ok", 128'(tag_ok), 128'd0);
    chk("reset_tag_out", tag_out, 128'd0);
    rst = 1'b0;
    tick();

    // Golden: all-zero state.
    gold = model_tag('0);
    run_check("golden", '0, gold, 1'b1, gold);

    // Single-bit corruptions at both ends of the tag.
    t = gold; t[0] = ~t[0];
    run_check("flip_bit0", '0, t, 1'b0, gold);
    t = gold; t[127] = ~t[127];
    run_check("flip_bit127", '0, t, 1'b0, gold);

    // Random vectors; odd iterations corrupt one random tag bit.
    for (int i = 0; i < 50; i++) begin
      st = rand_state();
      t  = model_tag(st);
      if (i % 2 == 1) begin
        k = $urandom_range(127, 0);
        ta = t;
        ta[k] = ~ta[k];
        run_check("random_bad", st, ta, 1'b0, t);
      end else begin
        run_check("random_good", st, t, 1'b1, t);
      end
    end

    // start during RUN with different data must be ignored.
    st = rand_state();
    t  = model_tag(st);
    sb = rand_state();
    tb2 = model_tag(sb);
    state_in = st; tag_in = t; start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    lat = 0;
    while (lat < 2000 && pulses == 0) begin
      if (lat == 300) begin
        state_in = sb; tag_in = tb2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
      if (done) pulses++;
    end
    start = 1'b0;
    chk("midrun_start_latency", 128'(lat), 128'd769);
    chk("midrun_start_tag_ok", 128'(tag_ok), 128'd1);
    chk("midrun_start_tag_out", tag_out, t);
    repeat (30) begin
      tick();
      if (done) pulses++;
    end
    chk("midrun_start_one_done", 128'(pulses), 128'd1);

    // Reset at cycle 400 of a run; tag_ok/tag_out were 1/nonzero beforehand.
    state_in = st; tag_in = t; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (400) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun_rst_busy", 128'(busy), 128'd0);
    chk("midrun_rst_done", 128'(done), 128'd0);
    chk("midrun_rst_tag_ok", 128'(tag_ok), 128'd0);
    chk("midrun_rst_tag_out", tag_out, 128'd0);
    pulses = 0;
    repeat (900) begin
      tick();
      if (done) pulses++;
    end
    chk("midrun_rst_no_done", 128'(pulses), 128'd0);
    run_check("after_rst", st, t, 1'b1, t);

    // Back-to-back: start held high, runs 770 clocks apart, tag_ok held between.
    st = rand_state();
    t  = model_tag(st);
    state_in = st; tag_in = t; start = 1'b1;
    pulses = 0; first_pulse = 0; second_pulse = 0; held_bad = 0;
    for (int c = 1; c <= 1600; c++) begin
      tick();
      if (done) begin
        pulses++;
        if (pulses == 1) first_pulse = c;
        if (pulses == 2) second_pulse = c;
      end else if (pulses == 1 && tag_ok !== 1'b1) begin
        held_bad++;
      end
    end
    start = 1'b0;
    chk("b2b_pulses", 128'(pulses), 128'd2);
    chk("b2b_first_done", 128'(first_pulse), 128'd770);
    chk("b2b_spacing", 128'(second_pulse - first_pulse), 128'd770);
    chk("b2b_tag_ok_held", 128'(held_bad), 128'd0);
    chk("b2b_tag_out", tag_out, t);
    // Drain the third run that was accepted while start stayed high.
    lat = 0;
    while (!done && lat < 2000) begin
      tick();
      lat++;
    end
    chk("b2b_third_result", 128'(tag_ok), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
